branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
Parametrised, registered successor to the combinational branch comparator. Takes both operands plus funct3 and resolves all six RV32 conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU). Produces taken, redirect PC and mispredict, with one register stage under a valid/ready handshake. Sits between the EX-stage operand muxes and the fetch-redirect/flush logic, and keeps saturating branch statistics counters.

Parameters:
XLEN, 32, operand/PC width (>= 8)
CNT_W, 16, width of each statistics counter

Ports:
clk  in  1  system clock; all state on rising edge
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
in_valid  in  1  operand bundle valid
in_ready  out  1  unit can accept bundle this cycle
a  in  XLEN  rs1 value
b  in  XLEN  rs2 value
funct3  in  3  branch kind
pc  in  XLEN  branch instruction PC
imm  in  XLEN  sign-extended B-immediate
pred_taken  in  1  front-end prediction
flush  in  1  kill in-flight result
out_valid  out  1  result register valid
out_ready  in  1  consumer accepts result
taken  out  1  branch condition true
mispredict  out  1  taken != registered pred_taken
illegal  out  1  funct3 is 010 or 011
redirect_pc  out  XLEN  pc+imm if taken else pc+4
neq  out  1  a != b (registered)
b_is_zero  out  1  b == 0 (registered)
lt  out  1  signed a < b (registered)
ltu  out  1  unsigned a < b (registered)
cnt_clr  in  1  synchronous clear of counters
cnt_branch  out  CNT_W  resolved branches
cnt_taken  out  CNT_W  resolved taken branches
cnt_mispred  out  CNT_W  resolved mispredicts

Behaviour:
- Reset (rst_n=0, async): every output register is 0: out_valid, taken, mispredict, illegal, neq, b_is_zero, lt, ltu, redirect_pc, all counters. in_ready=1 once out_valid=0 and flush=0.
- in_ready = !flush && (!out_valid || out_ready), combinational. Accept = in_valid && in_ready.
- On accept, all result fields are computed combinationally from the inputs and registered; out_valid=1 next cycle. Latency is exactly 1 cycle. Back-to-back accepts at full rate while out_ready=1.
- out_valid && !out_ready: the result register holds every field stable and in_ready=0. No bundle is lost or overwritten.
- Output handshake = out_valid && out_ready && !flush. Without a new accept in the same cycle, out_valid drops to 0 next cycle.
- flush=1: out_valid=0 next cycle regardless of other inputs. Flush beats accept and output handshake. Other data fields may hold stale values.
- Conditions: 000 eq=!neq; 001 neq; 100 lt; 101 !lt; 110 ltu; 111 !ltu. Signed compare is two's complement over XLEN; unsigned compare is over the full XLEN.
- funct3 010/011: illegal=1, taken=0, mispredict=pred_taken, redirect_pc=pc+4.
- redirect_pc arithmetic is modulo 2^XLEN; carry out is discarded (wrap-around).
- The flag outputs neq/b_is_zero/lt/ltu are registered from the same accepted bundle.
- Counters advance only on output handshake. cnt_branch+1 always; cnt_taken+1 if taken; cnt_mispred+1 if mispredict. Illegal bundles are counted in cnt_branch only.
- Counters saturate at 2^CNT_W-1 and never wrap.
- cnt_clr=1: all counters go to 0 next cycle. Clear beats a simultaneous increment.
- rst_n asserted mid-transaction: the result and counters are discarded immediately. Recovery needs no handshake.

Test Plan:
- BEQ a=3,b=3,pc=0x100,imm=0x20,pred=0, out_ready=1 -> next cycle out_valid=1,taken=1,mispredict=1,redirect_pc=0x120,neq=0; cnt_branch=1,cnt_mispred=1 after handshake.
- BLT vs BLTU a=0xFFFFFFFF,b=1 -> BLT taken=1,lt=1,ltu=0; BLTU taken=0,redirect_pc=pc+4.
- Backpressure: accept BNE a=3,b=1, hold out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0, outputs stable; out_ready=1 -> handshake, next bundle accepted same cycle.
- Wrap: pc=0xFFFFFFFC,BGE a=0,b=0,imm=8 -> taken=1,redirect_pc=0x00000004; funct3=010 -> illegal=1,taken=0.
- Flush: result pending with out_ready=0, assert flush with in_valid=1 -> out_valid=0 next cycle, nothing accepted, counters unchanged.
- CNT_W=2: 5 taken handshakes -> cnt_taken=3 (saturated); cnt_clr during a handshake -> all counters 0. Async rst_n low mid-stream -> outputs 0 without a clock edge.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates RV32 conditional branches, registers the
// result behind a valid/ready handshake and keeps saturating statistics.
`timescale 1ns/1ps

module branch_resolve_unit #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  a,
   input  logic [XLEN-1:0]  b,
   input  logic [2:0]       funct3,
   input  logic [XLEN-1:0]  pc,
   input  logic [XLEN-1:0]  imm,
   input  logic             pred_taken,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             taken,
   output logic             mispredict,
   output logic             illegal,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             neq,
   output logic             b_is_zero,
   output logic             lt,
   output logic             ltu,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] cnt_branch,
   output logic [CNT_W-1:0] cnt_taken,
   output logic [CNT_W-1:0] cnt_mispred
);

   localparam int unsigned PC_STEP = 4;

   // funct3 encodings of the conditional branches
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [0:0] {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   typedef struct packed {
      logic            taken;
      logic            mispredict;
      logic            illegal;
      logic            neq;
      logic            b_is_zero;
      logic            lt;
      logic            ltu;
      logic [XLEN-1:0] redirect_pc;
   } result_t;

   state_t  state_q, state_d;
   result_t res_q, res_d;
   logic    load_c;
   logic    out_fire_c;
   logic    cond_c;

   logic [CNT_W-1:0] cnt_branch_q, cnt_taken_q, cnt_mispred_q;

   // Saturating increment; holds at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic en);
      if (en && (v != {CNT_W{1'b1}})) begin
         return v + CNT_W'(1);
      end
      return v;
   endfunction

   // Upstream may only hand over a bundle when the result slot is free or draining.
   assign in_ready   = !flush && ((state_q == S_EMPTY) || out_ready);
   assign out_fire_c = (state_q == S_FULL) && out_ready && !flush;

   // Branch condition evaluation and result bundle for the incoming operands.
   always_comb begin
      res_d           = '0;
      cond_c          = 1'b0;
      res_d.neq       = (a != b);
      res_d.b_is_zero = (b == '0);
      res_d.lt        = ($signed(a) < $signed(b));
      res_d.ltu       = (a < b);
      res_d.illegal   = (funct3[2:1] == 2'b01);
      case (funct3)
         F3_BEQ:  cond_c = !res_d.neq;
         F3_BNE:  cond_c = res_d.neq;
         F3_BLT:  cond_c = res_d.lt;
         F3_BGE:  cond_c = !res_d.lt;
         F3_BLTU: cond_c = res_d.ltu;
         F3_BGEU: cond_c = !res_d.ltu;
         default: cond_c = 1'b0;
      endcase
      res_d.taken       = cond_c;
      res_d.mispredict  = (cond_c != pred_taken);
      // Sum wraps modulo 2^XLEN; carry out is dropped by the truncating width.
      res_d.redirect_pc = cond_c ? (pc + imm) : (pc + XLEN'(PC_STEP));
   end

   // Result slot occupancy: state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Result slot occupancy: next state and load enable; flush has top priority.
   always_comb begin
      state_d = state_q;
      load_c  = 1'b0;
      case (state_q)
         S_EMPTY: begin
            if (!flush && in_valid) begin
               state_d = S_FULL;
               load_c  = 1'b1;
            end
         end
         S_FULL: begin
            if (flush) begin
               state_d = S_EMPTY;
            end else if (out_ready) begin
               if (in_valid) begin
                  load_c = 1'b1;
               end else begin
                  state_d = S_EMPTY;
               end
            end
         end
      endcase
   end

   // Result register: captures a bundle only on accept, otherwise holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q <= '0;
      end else if (load_c) begin
         res_q <= res_d;
      end
   end

   // Statistics counters: advance on output handshake, clear wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_branch_q  <= '0;
         cnt_taken_q   <= '0;
         cnt_mispred_q <= '0;
      end else if (cnt_clr) begin
         cnt_branch_q  <= '0;
         cnt_taken_q   <= '0;
         cnt_mispred_q <= '0;
      end else if (out_fire_c) begin
         cnt_branch_q  <= sat_inc(cnt_branch_q, 1'b1);
         cnt_taken_q   <= sat_inc(cnt_taken_q, res_q.taken);
         cnt_mispred_q <= sat_inc(cnt_mispred_q, res_q.mispredict);
      end
   end

   assign out_valid   = (state_q == S_FULL);
   assign taken       = res_q.taken;
   assign mispredict  = res_q.mispredict;
   assign illegal     = res_q.illegal;
   assign redirect_pc = res_q.redirect_pc;
   assign neq         = res_q.neq;
   assign b_is_zero   = res_q.b_is_zero;
   assign lt          = res_q.lt;
   assign ltu         = res_q.ltu;
   assign cnt_branch  = cnt_branch_q;
   assign cnt_taken   = cnt_taken_q;
   assign cnt_mispred = cnt_mispred_q;

endmodule
